key_entry_ctrl: RTL and testbench

//  Sequences raw PS/2 set-2 scan bytes into two-digit decimal commands and arbitrates them against

---
 rtl/key_entry_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_key_entry_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_entry_ctrl.sv
// PS/2 set-2 scan bytes -> two-digit BCD commands, arbitrated with clap events on one command port.
// Optional CLAP_DEFER_EN: claps that cannot issue immediately are held in a one-deep pending flag.
module key_entry_ctrl #(
  parameter int TIMEOUT_CYCLES = 250_000_000,
  parameter int TO_W           = 28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  input  logic       clap,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic       cmd_kind,
  output logic [7:0] cmd_value,
  output logic [1:0] entry_state,
  output logic       busy,
  output logic       timeout
);
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_ONE = 2'b01, S_TWO = 2'b10, S_OUT = 2'b11} state_t;
  typedef enum logic [2:0] {K_NONE, K_DIGIT, K_ENTER, K_BKSP, K_ESC} key_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          r_state, w_state_nx;
  logic [3:0]      r_tens, r_ones, w_tens_nx, w_ones_nx;
  logic            r_brk, r_ext;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_cmd_valid, r_cmd_kind, r_timeout;
  logic [7:0]      r_cmd_value;
  key_t            w_key;
  logic [3:0]      w_digit;
  logic            w_make, w_to_hit, w_accept, w_free, w_entry_held;
  logic            w_load_entry, w_clap_fresh, w_clap_issue;

  // Only unprefixed make codes reach the key decoder; break/extended bytes are swallowed.
  assign w_make = scan_valid & ~r_brk & ~r_ext & (scan_code != 8'hF0) & (scan_code != 8'hE0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_brk <= 1'b0;
      r_ext <= 1'b0;
    end else if (scan_valid) begin
      if (r_brk) begin
        r_brk <= 1'b0;
        r_ext <= 1'b0;
      end else if (scan_code == 8'hF0) begin
        r_brk <= 1'b1;
      end else if (r_ext) begin
        r_ext <= 1'b0;
      end else if (scan_code == 8'hE0) begin
        r_ext <= 1'b1;
      end
    end
  end

  always_comb begin
    w_key   = K_NONE;
    w_digit = 4'd0;
    case (scan_code)
      8'h45: begin w_key = K_DIGIT; w_digit = 4'd0; end
      8'h16: begin w_key = K_DIGIT; w_digit = 4'd1; end
      8'h1E: begin w_key = K_DIGIT; w_digit = 4'd2; end
      8'h26: begin w_key = K_DIGIT; w_digit = 4'd3; end
      8'h25: begin w_key = K_DIGIT; w_digit = 4'd4; end
      8'h2E: begin w_key = K_DIGIT; w_digit = 4'd5; end
      8'h36: begin w_key = K_DIGIT; w_digit = 4'd6; end
      8'h3D: begin w_key = K_DIGIT; w_digit = 4'd7; end
      8'h3E: begin w_key = K_DIGIT; w_digit = 4'd8; end
      8'h46: begin w_key = K_DIGIT; w_digit = 4'd9; end
      8'h5A: w_key = K_ENTER;
      8'h66: w_key = K_BKSP;
      8'h76: w_key = K_ESC;
      default: w_key = K_NONE;
    endcase
    if (!w_make) w_key = K_NONE;
  end

  // Any byte restarts the idle window, even one the filter swallows.
  assign w_to_hit = ((r_state == S_ONE) || (r_state == S_TWO)) & ~scan_valid & (r_to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset || scan_valid || r_state == S_IDLE || r_state == S_OUT) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != TO_LAST) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_accept     = r_cmd_valid & cmd_ready;
  assign w_free       = ~r_cmd_valid | w_accept;
  assign w_entry_held = r_cmd_valid & ~r_cmd_kind;

  always_comb begin
    w_state_nx   = r_state;
    w_tens_nx    = r_tens;
    w_ones_nx    = r_ones;
    w_load_entry = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_key == K_DIGIT) begin
          w_tens_nx  = w_digit;
          w_state_nx = S_ONE;
        end
      end
      S_ONE: begin
        if (w_to_hit) begin
          w_state_nx = S_IDLE;
        end else if (w_key == K_DIGIT) begin
          w_ones_nx  = w_digit;
          w_state_nx = S_TWO;
        end else if (w_key == K_ENTER) begin
          // Single digit commits as {0,d}; shift it into the ones slot.
          w_tens_nx    = 4'd0;
          w_ones_nx    = r_tens;
          w_state_nx   = S_OUT;
          w_load_entry = w_free;
        end else if (w_key == K_BKSP || w_key == K_ESC) begin
          w_state_nx = S_IDLE;
        end
      end
      S_TWO: begin
        if (w_to_hit) begin
          w_state_nx = S_IDLE;
        end else if (w_key == K_ENTER) begin
          w_state_nx   = S_OUT;
          w_load_entry = w_free;
        end else if (w_key == K_BKSP) begin
          w_state_nx = S_ONE;
        end else if (w_key == K_ESC) begin
          w_state_nx = S_IDLE;
        end
      end
      S_OUT: begin
        if (w_entry_held) begin
          if (w_accept) w_state_nx = S_IDLE;
        end else if (w_free) begin
          w_load_entry = 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign w_clap_fresh = clap & ~r_cmd_valid & (r_state == S_IDLE);

`ifdef CLAP_DEFER_EN
  logic r_clap_pend;
  logic w_in_entry;

  assign w_in_entry   = (r_state == S_ONE) || (r_state == S_TWO);
  assign w_clap_issue = ~w_load_entry & w_free & ~w_in_entry & (r_clap_pend | w_clap_fresh);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clap_pend <= 1'b0;
    end else if (clap && !w_clap_fresh) begin
      r_clap_pend <= 1'b1;
    end else if (w_clap_issue) begin
      r_clap_pend <= 1'b0;
    end
  end
`else
  assign w_clap_issue = w_clap_fresh;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cmd_valid <= 1'b0;
      r_cmd_kind  <= 1'b0;
      r_cmd_value <= 8'h00;
      r_timeout   <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_timeout <= w_to_hit;
      if (w_load_entry) begin
        r_cmd_valid <= 1'b1;
        r_cmd_kind  <= 1'b0;
        r_cmd_value <= {w_tens_nx, w_ones_nx};
      end else if (w_clap_issue) begin
        r_cmd_valid <= 1'b1;
        r_cmd_kind  <= 1'b1;
        r_cmd_value <= 8'h00;
      end else if (w_accept) begin
        r_cmd_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    r_tens <= w_tens_nx;
    r_ones <= w_ones_nx;
  end

  assign cmd_valid   = r_cmd_valid;
  assign cmd_kind    = r_cmd_kind;
  assign cmd_value   = r_cmd_value;
  assign entry_state = r_state;
  assign busy        = (r_state != S_IDLE);
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Bench for key_entry_ctrl: directed sequences plus random traffic against a digit-queue reference model.
module tb_key_entry_ctrl;
  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic       clap = 1'b0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid, cmd_kind;
  logic [7:0] cmd_value;
  logic [1:0] entry_state;
  logic       busy, timeout;

  key_entry_ctrl #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .scan_code(scan_code), .scan_valid(scan_valid),
    .clap(clap), .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_kind(cmd_kind),
    .cmd_value(cmd_value), .entry_state(entry_state), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;
  int n_to_seen = 0;
  bit any_busy = 1'b0;
  logic [8:0] acc_q[$];

  // Reference model: typed digits kept as a queue, "done" marks a committed entry.
  bit         m_brk, m_ext, m_done, m_ov, m_ok, m_pend, m_to;
  logic [7:0] m_oval;
  int         m_dig[$];
  int         m_idle;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int keyof(input logic [7:0] c);
    logic [7:0] dc[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    for (int i = 0; i < 10; i++) if (dc[i] == c) return i;
    if (c == 8'h5A) return 10;
    if (c == 8'h66) return 11;
    if (c == 8'h76) return 12;
    return -1;
  endfunction

  function automatic logic [1:0] m_state();
    if (m_done) return 2'd3;
    return 2'(m_dig.size());
  endfunction

  function automatic logic [8:0] qget(input int i);
    if (i < acc_q.size()) return acc_q[i];
    return 9'h1FF;
  endfunction

  task automatic model_step(input bit sv, input logic [7:0] code, input bit cl, input bit rdy, input bit rst);
    bit acc, fre, in_entry, was_idle, load, issue, fresh;
    int k;
    logic [7:0] val;
    if (rst) begin
      m_brk = 0; m_ext = 0; m_done = 0; m_ov = 0; m_ok = 0; m_oval = 0;
      m_pend = 0; m_to = 0; m_idle = 0; m_dig.delete();
      return;
    end
    acc = m_ov && rdy;
    fre = !m_ov || acc;
    in_entry = !m_done && m_dig.size() > 0;
    was_idle = !m_done && m_dig.size() == 0;
    k = -1;
    if (sv) begin
      if (m_brk) begin m_brk = 0; m_ext = 0; end
      else if (code == 8'hF0) m_brk = 1;
      else if (m_ext) m_ext = 0;
      else if (code == 8'hE0) m_ext = 1;
      else k = keyof(code);
    end
    load = 0;
    m_to = 0;
    if (m_done) begin
      if (m_ov && !m_ok) begin
        if (acc) begin m_done = 0; m_dig.delete(); end
      end else if (fre) load = 1;
    end else if (in_entry && !sv && m_idle == TO - 1) begin
      m_dig.delete();
      m_to = 1;
    end else if (k >= 0 && k <= 9) begin
      if (m_dig.size() < 2) m_dig.push_back(k);
    end else if (k == 10 && in_entry) begin
      m_done = 1;
      load = fre;
    end else if (k == 11) begin
      if (m_dig.size() > 0) m_dig.pop_back();
    end else if (k == 12) begin
      m_dig.delete();
    end
    if (sv || !in_entry) m_idle = 0;
    else if (m_idle < TO - 1) m_idle++;
    val = 8'h00;
    if (load) val = (m_dig.size() == 1) ? 8'(m_dig[0]) : 8'(m_dig[0] * 16 + m_dig[1]);
    fresh = cl && !m_ov && was_idle;
`ifdef CLAP_DEFER_EN
    issue = !load && fre && !in_entry && (m_pend || fresh);
    if (cl && !fresh) m_pend = 1;
    else if (issue) m_pend = 0;
`else
    issue = fresh;
`endif
    if (load) begin m_ov = 1; m_ok = 0; m_oval = val; end
    else if (issue) begin m_ov = 1; m_ok = 1; m_oval = 8'h00; end
    else if (acc) m_ov = 0;
  endtask

  task automatic tick(input bit sv, input logic [7:0] code, input bit cl, input bit rdy, input bit rst);
    @(negedge clk);
    if (chk_on) begin
      chk("ctl", {cmd_valid, entry_state, busy, timeout}, {m_ov, m_state(), m_state() != 2'd0, m_to});
      if (m_ov) chk("cmd", {cmd_kind, cmd_value}, {m_ok, m_oval});
    end
    if (timeout === 1'b1) n_to_seen++;
    if (entry_state !== 2'b00) any_busy = 1'b1;
    if (cmd_valid === 1'b1 && rdy && !rst) acc_q.push_back({cmd_kind, cmd_value});
    scan_valid = sv; scan_code = code; clap = cl; cmd_ready = rdy; reset = rst;
    model_step(sv, code, cl, rdy, rst);
  endtask

  task automatic key(input logic [7:0] b, input bit rdy);
    tick(1'b1, b, 1'b0, rdy, 1'b0);
    tick(1'b0, 8'h00, 1'b0, rdy, 1'b0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    logic [7:0] codes[16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                              8'h3E, 8'h46, 8'h5A, 8'h66, 8'h76, 8'hF0, 8'hE0, 8'h1C};
    logic [7:0] seq1[7] = '{8'h1E, 8'hF0, 8'h1E, 8'h36, 8'hF0, 8'h36, 8'h5A};
    logic [7:0] seqx[6] = '{8'hE0, 8'h5A, 8'hE0, 8'hF0, 8'h5A, 8'h76};
    logic [7:0] c;
    int exp_n;

    tick(0, 8'h00, 0, 0, 1);
    tick(0, 8'h00, 0, 0, 1);
    chk_on = 1'b1;
    idle(2, 1'b1);

    // Reset mid-entry, then reset with a command held.
    key(8'h3D, 1'b1); key(8'h25, 1'b1);
    tick(0, 8'h00, 0, 1, 1); tick(0, 8'h00, 0, 1, 1);
    tick(0, 8'h00, 0, 1, 0);
    chk("rst_outs", {cmd_valid, cmd_kind, cmd_value, entry_state, busy, timeout}, 14'h0);
    key(8'h2E, 1'b0); key(8'h5A, 1'b0);
    acc_q.delete();
    tick(0, 8'h00, 0, 0, 1); tick(0, 8'h00, 0, 0, 1);
    tick(0, 8'h00, 0, 1, 0);
    chk("rst_held", {cmd_valid, entry_state}, 3'b000);
    idle(3, 1'b1);
    chk("rst_ncmd", acc_q.size(), 0);

    // 1E,F0,1E,36,F0,36,5A -> 26, one cycle after ENTER.
    acc_q.delete();
    for (int i = 0; i < 6; i++) key(seq1[i], 1'b1);
    tick(1, 8'h5A, 0, 1, 0);
    #6 chk("s1_lat", cmd_valid, 1'b1);
    idle(4, 1'b1);
    chk("s1_n", acc_q.size(), 1);
    chk("s1_v", qget(0), {1'b0, 8'h26});

    acc_q.delete();
    key(8'h16, 1'b1); key(8'h5A, 1'b1); idle(3, 1'b1);
    chk("s2_n", acc_q.size(), 1);
    chk("s2_v", qget(0), {1'b0, 8'h01});

    acc_q.delete();
    key(8'h16, 1'b1); key(8'h66, 1'b1); key(8'h25, 1'b1); key(8'h45, 1'b1); key(8'h5A, 1'b1);
    idle(3, 1'b1);
    chk("s3_n", acc_q.size(), 1);
    chk("s3_v", qget(0), {1'b0, 8'h40});

    // Idle timeout after a single digit.
    acc_q.delete();
    n_to_seen = 0;
    key(8'h3D, 1'b1);
    idle(TO + 20, 1'b1);
    chk("to_pulse", n_to_seen, 1);
    chk("to_state", entry_state, 2'b00);
    chk("to_ncmd", acc_q.size(), 0);

    // Commit with clap in the same cycle while the consumer is stalled.
    acc_q.delete();
    key(8'h2E, 1'b0); key(8'h46, 1'b0);
    tick(1, 8'h5A, 1, 0, 0);
    idle(4, 1'b0);
    idle(6, 1'b1);
`ifdef CLAP_DEFER_EN
    exp_n = 2;
    chk("s6_v1", qget(1), {1'b1, 8'h00});
`else
    exp_n = 1;
`endif
    chk("s6_n", acc_q.size(), exp_n);
    chk("s6_v0", qget(0), {1'b0, 8'h59});

    // Extended and break-prefixed keys never reach the entry logic.
    acc_q.delete();
    any_busy = 1'b0;
    for (int i = 0; i < 6; i++) key(seqx[i], 1'b1);
    idle(3, 1'b1);
    chk("ext_ncmd", acc_q.size(), 0);
    chk("ext_idle", any_busy, 1'b0);

    // Clap in IDLE alone, then clap together with a first digit.
    acc_q.delete();
    tick(0, 8'h00, 1, 1, 0); idle(3, 1'b1);
    tick(1, 8'h1E, 1, 1, 0); idle(3, 1'b1);
    chk("clap_n", acc_q.size(), 2);
    chk("clap_v", qget(1), {1'b1, 8'h00});
    chk("clap_state", entry_state, 2'b01);
    key(8'h76, 1'b1);

    // Random traffic with occasional long gaps and resets.
    for (int i = 0; i < 4000; i++) begin
      c = ($urandom_range(0, 9) == 0) ? 8'($urandom) : codes[$urandom_range(0, 15)];
      if ($urandom_range(0, 249) == 0) idle(TO + 10, 1'($urandom_range(0, 1)));
      tick($urandom_range(0, 2) == 0, c, $urandom_range(0, 15) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 599) == 0);
    end
    idle(3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
